// File: rtl/mac_accumulator.sv
// Multiply-accumulate stage: streams len operand pairs through an array multiplier and
// sums the products. `define MAC_SATURATE_EN to clamp on overflow instead of wrapping.

module array_multiplier #(
   parameter int A_W = 4,
   parameter int B_W = 4
) (
   input  logic [A_W-1:0]     i_a,
   input  logic [B_W-1:0]     i_b,
   output logic [A_W+B_W-1:0] o_p
);

   logic [B_W-1:0][A_W-1:0] w_pp;
   logic [A_W:0]            w_row;
   logic [A_W:0]            w_nrow;
   logic [B_W-1:0]          w_prod_lo;
   logic                    w_c;
   logic                    w_x;
   logic                    w_y;

   generate
      for (genvar gi = 0; gi < B_W; gi++) begin : g_pp_row
         for (genvar gj = 0; gj < A_W; gj++) begin : g_pp_col
            assign w_pp[gi][gj] = i_a[gj] & i_b[gi];
         end
      end
   endgenerate

   // Each row is a ripple of full-adder cells adding the next partial product to the
   // upper bits of the previous row; the row's LSB retires as one product bit.
   always_comb begin
      w_row     = {1'b0, w_pp[0]};
      w_nrow    = '0;
      w_prod_lo = '0;
      w_c       = 1'b0;
      w_x       = 1'b0;
      w_y       = 1'b0;
      w_prod_lo[0] = w_row[0];
      for (int r = 1; r < B_W; r++) begin
         w_c = 1'b0;
         for (int c = 0; c < A_W; c++) begin
            w_x       = w_pp[r][c];
            w_y       = w_row[c+1];
            w_nrow[c] = w_x ^ w_y ^ w_c;
            w_c       = (w_x & w_y) | (w_c & (w_x ^ w_y));
         end
         w_nrow[A_W]  = w_c;
         w_row        = w_nrow;
         w_prod_lo[r] = w_row[0];
      end
   end

   assign o_p = {w_row[A_W:1], w_prod_lo};

endmodule

module mac_accumulator #(
   parameter int ACC_W = 16,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       a,
   input  logic [3:0]       b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] result,
   output logic             busy,
   output logic             overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [LEN_W-1:0] r_count;
   logic [ACC_W-1:0] r_acc;
   logic             r_ovf;
   logic             r_pending;
   logic [3:0]       r_a;
   logic [3:0]       r_b;
   logic [7:0]       w_prod;
   logic [ACC_W:0]   w_sum;
   logic             w_accept;
   logic             w_start_ok;
   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_busy;

   array_multiplier #(.A_W(4), .B_W(4)) u_mul (
      .i_a (r_a),
      .i_b (r_b),
      .o_p (w_prod)
   );

   assign w_sum      = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, w_prod};
   assign w_accept   = in_valid && w_in_ready;
   assign w_start_ok = (r_state == S_IDLE) && start;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      w_busy       = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (start) begin
               w_state_next = (len != '0) ? S_ACCUM : S_DONE;
            end
         end
         S_ACCUM: begin
            w_in_ready = 1'b1;
            if (in_valid && (r_count == LEN_W'(1))) begin
               w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_state_next = S_DONE;
         end
         S_DONE: begin
            w_out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // The pending flag tracks "operand registers hold a product not yet summed".
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count   <= '0;
         r_acc     <= '0;
         r_ovf     <= 1'b0;
         r_pending <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
      end else begin
         r_pending <= w_accept;
         if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_count <= r_count - LEN_W'(1);
         end
         if (w_start_ok) begin
            r_count <= len;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
         end else if (r_pending) begin
            if (w_sum[ACC_W]) begin
               r_ovf <= 1'b1;
            end
`ifdef MAC_SATURATE_EN
            r_acc <= w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
            r_acc <= w_sum[ACC_W-1:0];
`endif
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign busy      = w_busy;
   assign result    = r_acc;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a 16-bit and an 8-bit instance share stimulus;
// the 8-bit one exercises overflow (expectation follows MAC_SATURATE_EN).

module tb_mac_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] len;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_ready;

   logic        in_ready16, out_valid16, busy16, overflow16;
   logic [15:0] result16;
   logic        in_ready8, out_valid8, busy8, overflow8;
   logic [7:0]  result8;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mac_accumulator #(.ACC_W(16), .LEN_W(4)) u_dut16 (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready16),
      .a         (a),
      .b         (b),
      .out_valid (out_valid16),
      .out_ready (out_ready),
      .result    (result16),
      .busy      (busy16),
      .overflow  (overflow16)
   );

   mac_accumulator #(.ACC_W(8), .LEN_W(4)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready8),
      .a         (a),
      .b         (b),
      .out_valid (out_valid8),
      .out_ready (out_ready),
      .result    (result8),
      .busy      (busy8),
      .overflow  (overflow8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      start     = 1'b0;
      len       = 4'd0;
      in_valid  = 1'b0;
      a         = 4'd0;
      b         = 4'd0;
      out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] exp_ovf8;
`ifdef MAC_SATURATE_EN
      exp_ovf8 = 8'd255;
`else
      exp_ovf8 = 8'd194;
`endif
      idle_inputs();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;

      // Reset state
      check("rst_busy",      busy16,      0);
      check("rst_in_ready",  in_ready16,  0);
      check("rst_out_valid", out_valid16, 0);
      check("rst_result",    result16,    0);
      check("rst_overflow",  overflow16,  0);

      // Three products: 15 + 225 + 0 = 240
      start = 1'b1; len = 4'd3;                               // cycle 0
      step(); start = 1'b0; in_valid = 1'b1; a = 4'd3;  b = 4'd5;   // cycle 1
      check("t1_in_ready_c1", in_ready16, 1);
      step(); a = 4'd15; b = 4'd15;                           // cycle 2
      check("t1_in_ready_c2", in_ready16, 1);
      step(); a = 4'd0;  b = 4'd9;                            // cycle 3
      check("t1_in_ready_c3", in_ready16, 1);
      step(); in_valid = 1'b0; a = 4'd15; b = 4'd15;          // cycle 4 (drain)
      check("t1_drain_in_ready",  in_ready16,  0);
      check("t1_drain_out_valid", out_valid16, 0);
      check("t1_drain_busy",      busy16,      1);
      step();                                                 // cycle 5
      check("t1_out_valid", out_valid16, 1);
      check("t1_result",    result16,    240);
      check("t1_overflow",  overflow16,  0);
      check("t1_out_valid8", out_valid8, 1);
      check("t1_result8",    result8,    240);
      check("t1_overflow8",  overflow8,  0);
      out_ready = 1'b1;
      step(); out_ready = 1'b0;
      check("t1_idle_busy",      busy16,      0);
      check("t1_idle_out_valid", out_valid16, 0);

      // Zero-length run
      start = 1'b1; len = 4'd0;
      check("t2_in_ready_c0", in_ready16, 0);
      step(); start = 1'b0;
      check("t2_out_valid", out_valid16, 1);
      check("t2_result",    result16,    0);
      check("t2_in_ready",  in_ready16,  0);
      out_ready = 1'b1;
      step(); out_ready = 1'b0;
      check("t2_idle_busy", busy16, 0);

      // Input gap: 49 + 6 = 55, junk operands during the gap must not be captured
      start = 1'b1; len = 4'd2;
      step(); start = 1'b0; in_valid = 1'b1; a = 4'd7; b = 4'd7;
      check("t3_in_ready_c1", in_ready16, 1);
      for (int i = 0; i < 3; i++) begin
         step(); in_valid = 1'b0; a = 4'd15; b = 4'd15;
         check($sformatf("t3_gap_in_ready_%0d", i), in_ready16, 1);
      end
      step(); in_valid = 1'b1; a = 4'd2; b = 4'd3;
      check("t3_in_ready_c5", in_ready16, 1);
      step(); in_valid = 1'b0;
      check("t3_drain_in_ready", in_ready16, 0);
      step();
      check("t3_out_valid", out_valid16, 1);
      check("t3_result",    result16,    55);
      out_ready = 1'b1;
      step(); out_ready = 1'b0;

      // Overflow: 225 + 225 = 450
      start = 1'b1; len = 4'd2;
      step(); start = 1'b0; in_valid = 1'b1; a = 4'd15; b = 4'd15;
      step();
      step(); in_valid = 1'b0;
      check("t4_ovf8_midrun", overflow8, 0);
      step();
      check("t4_out_valid8", out_valid8, 1);
      check("t4_result16",   result16,   450);
      check("t4_overflow16", overflow16, 0);
      check("t4_result8",    result8,    {24'd0, exp_ovf8});
      check("t4_overflow8",  overflow8,  1);
      out_ready = 1'b1;
      step(); out_ready = 1'b0;
      check("t4_ovf8_sticky_idle", overflow8, 1);

      // Backpressure: len=1, (2,2) -> 4; start pulses in DONE are ignored
      start = 1'b1; len = 4'd1;
      step(); start = 1'b0; in_valid = 1'b1; a = 4'd2; b = 4'd2;
      check("t5_ovf8_cleared", overflow8, 0);
      step(); in_valid = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         start = 1'b1; len = 4'd5; in_valid = 1'b1; a = 4'd9; b = 4'd9;
         check($sformatf("t5_hold_valid_%0d", i),  out_valid16, 1);
         check($sformatf("t5_hold_result_%0d", i), result16,    4);
         check($sformatf("t5_hold_busy_%0d", i),   busy16,      1);
         step();
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("t5_release_valid", out_valid16, 1);
      check("t5_release_result", result16, 4);
      step(); out_ready = 1'b0;
      check("t5_idle_busy",      busy16,      0);
      check("t5_idle_out_valid", out_valid16, 0);

      // Reset mid-run, then a fresh len=1 run with (4,4) -> 16
      start = 1'b1; len = 4'd3;
      step(); start = 1'b0; in_valid = 1'b1; a = 4'd5; b = 4'd5;
      step(); in_valid = 1'b0; rst = 1'b1;
      step(); rst = 1'b0;
      check("t6_rst_busy",      busy16,      0);
      check("t6_rst_in_ready",  in_ready16,  0);
      check("t6_rst_out_valid", out_valid16, 0);
      check("t6_rst_result",    result16,    0);
      check("t6_rst_overflow",  overflow16,  0);
      start = 1'b1; len = 4'd1;
      step(); start = 1'b0; in_valid = 1'b1; a = 4'd4; b = 4'd4;
      step(); in_valid = 1'b0;
      step();
      check("t6_out_valid", out_valid16, 1);
      check("t6_result",    result16,    16);
      check("t6_busy8",     busy8,       1);
      check("t6_in_ready8", in_ready8,   0);
      out_ready = 1'b1;
      step(); out_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential multiply-accumulate stage downstream of `array_multiplier`. It accepts a programmed number of 4-bit operand pairs over a valid/ready handshake and registers each pair. It feeds the registered pair to an internal `array_multiplier` instance and sums the 8-bit products into an accumulator. The final dot-product is presented on a held valid/ready output port.

## Interface
Parameters:
- `ACC_W`, default 16: accumulator and result width; legal range 8..32.
- `LEN_W`, default 4: width of the length field; a run holds at most 2^LEN_W−1 products.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a run; sampled only in IDLE.
- `len`  in  LEN_W: number of products in the run; sampled with `start`.
- `in_valid`  in  1: operand pair `a`/`b` is valid.
- `in_ready`  out  1: block accepts a pair this cycle.
- `a`  in  4: multiplicand.
- `b`  in  4: multiplier.
- `out_valid`  out  1: `result` is valid.
- `out_ready`  in  1: consumer takes `result`.
- `result`  out  ACC_W: accumulated sum.
- `busy`  out  1: high in every state except IDLE.
- `overflow`  out  1: sticky flag; an add exceeded ACC_W bits during the current run.

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE
  - `in_ready`=0 and `out_valid`=0.
  - `start` with `len`≠0: load the remaining-count register with `len`, clear the accumulator and `overflow`, go to ACCUM.
  - `start` with `len`=0: clear the accumulator and `overflow`, go directly to DONE.
- ACCUM
  - `in_ready`=1.
  - Accept occurs when `in_valid` && `in_ready`.
  - On accept: register `a`/`b` into the operand registers, set the pending flag, decrement the count.
  - The accept that takes the count to 0 moves the state to DRAIN.
  - No accept: the count holds.
- Product path
  - The registered operands drive `array_multiplier` combinationally.
  - On any cycle where the pending flag is set, the accumulator adds the zero-extended 8-bit product.
  - The pending flag clears whenever no new accept occurs.
- DRAIN
  - `in_ready`=0.
  - The final pending product is added.
  - The next state is DONE.
- DONE
  - `out_valid`=1 and `result`=accumulator; both are held stable until `out_ready`.
  - `out_valid` && `out_ready`: go to IDLE.
- Arithmetic
  - Sums are computed at ACC_W+1 bits.
  - If the carry-out is set, `overflow` is set and stays set until the next `start`.
  - Wrap or saturate behaviour is selected by the configuration macro.
- `start` outside IDLE is ignored, and `len` is not re-sampled.
- `in_valid` outside ACCUM is ignored, and no data is captured.

## Timing
- Reset values: state IDLE, accumulator 0, `result` 0, `out_valid` 0, `in_ready` 0, `busy` 0, `overflow` 0, count 0, pending flag 0.
- `rst` asserted in any state, including mid-run or in DONE, discards all in-flight data and produces the reset values on the next edge.
- Pair accepted at cycle k: its product is added at the cycle k+1 edge and is visible in the accumulator at cycle k+2.
- Back-to-back run with N pairs and `in_valid` held high:
  - `start` at cycle 0.
  - Accepts at cycles 1..N.
  - DRAIN at cycle N+1.
  - `out_valid` high from cycle N+2.
- `len`=0 with `start` at cycle 0: `out_valid` high at cycle 1.
- `in_valid` gaps stretch the ACCUM phase and do not alter the sum.
- DONE with `out_ready` at cycle t: `busy`=0 at t+1. A new `start` is accepted at t+1 at the earliest.

## Configuration
- `MAC_SATURATE_EN` defined:
  - On carry-out, the accumulator clamps to all ones (2^ACC_W−1).
  - It stays clamped for the rest of the run.
  - `overflow` is set.
- `MAC_SATURATE_EN` undefined:
  - The accumulator wraps modulo 2^ACC_W.
  - `overflow` is still set.

## Test plan
- Sum of three products, ACC_W=16: `len`=3, pairs (3,5), (15,15), (0,9) streamed with `in_valid` held high → `result`=240 with `out_valid` at cycle 5, `overflow`=0.
- Zero-length run: `len`=0 → `out_valid` at cycle 1, `result`=0, `in_ready` never asserted.
- Input gap: `len`=2, pair (7,7), three idle cycles, then (2,3) → `result`=55, with `in_ready` high throughout the ACCUM phase.
- Overflow, ACC_W=8: `len`=2, pairs (15,15), (15,15) → without the macro `result`=194 and `overflow`=1; with `MAC_SATURATE_EN` `result`=255 and `overflow`=1.
- Output backpressure: `out_ready` held low for 4 cycles in DONE while pulsing `start` → `result` stable and `busy`=1 throughout, `start` ignored; IDLE on the cycle after `out_ready`.
- Reset mid-run: `rst` asserted after 1 of 3 accepts → all outputs at reset values on the next cycle; a fresh `len`=1 run with pair (4,4) → `result`=16.
